// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte-splits misaligned
// accesses and extends load results for the register file.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 4
`endif
`ifndef MASK_B
`define MASK_B 4'b0001
`endif
`ifndef MASK_H
`define MASK_H 4'b0011
`endif
`ifndef MASK_W
`define MASK_W 4'b1111
`endif

module load_store_unit (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [`MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [`REG_DATA_WIDTH-1:0] req_wdata,
    output logic                       resp_valid,
    output logic [`REG_DATA_WIDTH-1:0] resp_rdata,
    output logic                       resp_err,
    output logic                       mem_rd_en,
    output logic                       mem_wr_en,
    output logic [`MASK_WIDTH-1:0]     mem_mask,
    output logic [`MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [`REG_DATA_WIDTH-1:0] mem_wr_data,
    input  logic [`REG_DATA_WIDTH-1:0] mem_rd_data
);

    localparam int AW = `MEM_ADDR_WIDTH;
    localparam int DW = `REG_DATA_WIDTH;
    localparam int MW = `MASK_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]    k;
    logic [1:0]    k_nxt;

    logic          r_we;
    logic [2:0]    r_f3;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_err;
    logic [DW-1:0] asm_q;

    logic          accept;
    logic          legal_in;
    logic          is_half;
    logic          is_word;
    logic          aligned;
    logic [1:0]    last_k;
    logic [7:0]    wbyte;
    logic [DW-1:0] ext_data;

    assign accept = req_valid && req_ready;

    // Classify the incoming funct3 as a legal load/store width.
    always_comb begin
        legal_in = 1'b0;
        if (req_we) begin
            legal_in = (req_funct3 <= 3'b010);
        end else begin
            unique case (req_funct3)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101: legal_in = 1'b1;
                default:        legal_in = 1'b0;
            endcase
        end
    end

    // Access size, alignment and number of beats for the held request.
    always_comb begin
        is_half = (r_f3[1:0] == 2'b01);
        is_word = (r_f3[1:0] == 2'b10);
        aligned = 1'b1;
        last_k  = 2'd0;
        if (is_half && r_addr[0]) begin
            aligned = 1'b0;
            last_k  = 2'd1;
        end else if (is_word && (r_addr[1:0] != 2'b00)) begin
            aligned = 1'b0;
            last_k  = 2'd3;
        end
        wbyte = r_wdata[{k, 3'b000} +: 8];
    end

    // Sign/zero extension of the assembled load data.
    always_comb begin
        ext_data = asm_q;
        unique case (r_f3)
            3'b000:  ext_data = {{(DW-8){asm_q[7]}}, asm_q[7:0]};
            3'b001:  ext_data = {{(DW-16){asm_q[15]}}, asm_q[15:0]};
            3'b100:  ext_data = {{(DW-8){1'b0}}, asm_q[7:0]};
            3'b101:  ext_data = {{(DW-16){1'b0}}, asm_q[15:0]};
            default: ext_data = asm_q;
        endcase
    end

    // Next-state logic and all outputs; reset forces outputs quiet.
    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_err    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_mask    = '0;
        mem_addr    = '0;
        mem_wr_data = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                k_nxt     = 2'd0;
                if (req_valid) begin
                    state_nxt = legal_in ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                mem_rd_en = !r_we;
                mem_wr_en = r_we;
                mem_addr  = r_addr + AW'(k);
                if (!aligned) begin
                    mem_mask = MW'(`MASK_B);
                end else if (is_word) begin
                    mem_mask = MW'(`MASK_W);
                end else if (is_half) begin
                    mem_mask = MW'(`MASK_H);
                end else begin
                    mem_mask = MW'(`MASK_B);
                end
                if (r_we) begin
                    mem_wr_data = aligned ? r_wdata
                                : {{(DW-8){1'b0}}, wbyte};
                end
                if (k == last_k) begin
                    state_nxt = RESP;
                    k_nxt     = 2'd0;
                end else begin
                    k_nxt = k + 2'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                if (!r_err && !r_we) begin
                    resp_rdata = ext_data;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                k_nxt     = 2'd0;
            end
        endcase
        if (rst) begin
            req_ready   = 1'b0;
            resp_valid  = 1'b0;
            resp_rdata  = '0;
            resp_err    = 1'b0;
            mem_rd_en   = 1'b0;
            mem_wr_en   = 1'b0;
            mem_mask    = '0;
            mem_addr    = '0;
            mem_wr_data = '0;
        end
    end

    // State and beat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= 2'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Capture the request and assemble load data beat by beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            asm_q   <= '0;
        end else if (accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_err   <= !legal_in;
            asm_q   <= '0;
        end else if (state == ACCESS && !r_we) begin
            if (aligned) begin
                asm_q <= mem_rd_data;
            end else begin
                asm_q[{k, 3'b000} +: 8] <= mem_rd_data[7:0];
            end
        end
    end

endmodule
